// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS32 core: shared word memory
// serving a read-only fetch port and a load/store data port, each with a
// req/ack handshake and a fixed number of wait states per access.
module mips_mem_responder #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 1,
    parameter bit          DPRIO = 1'b1
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          busy
);

    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_CNT  = 4'(WAIT);
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAITS,
        ST_ACK
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    logic [31:0] mem [DEPTH];

    state_t        state_q, state_d;
    port_t         port_q, port_d;
    port_t         rr_q, rr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    port_t         gnt;
    logic          fire;
    port_t         f_port;
    logic [AW-1:0] f_addr;
    logic          f_we;
    logic [31:0]   f_wdata;
    logic          f_oor;
    logic [IW-1:0] f_idx;
    logic [31:0]   mem_rd;
    logic          mem_we;

    // Arbitration between simultaneous requests; rr_q records the last granted port.
    always_comb begin
        gnt = PORT_I;
        if (i_req && d_req) begin
            if (DPRIO) begin
                gnt = PORT_D;
            end else begin
                gnt = (rr_q == PORT_D) ? PORT_I : PORT_D;
            end
        end else if (d_req) begin
            gnt = PORT_D;
        end
    end

    // Next-state, operand latching and memory access on the edge entering ACK.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        fire      = 1'b0;
        f_port    = port_q;
        f_addr    = addr_q;
        f_we      = we_q;
        f_wdata   = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    port_d  = gnt;
                    rr_d    = gnt;
                    addr_d  = (gnt == PORT_D) ? d_addr : i_addr;
                    we_d    = (gnt == PORT_D) && d_we;
                    wdata_d = d_wdata;
                    cnt_d   = WAIT_CNT;
                    if (WAIT == 0) begin
                        // No wait states: the access commits on the grant
                        // edge itself, so it uses the live operands.
                        state_d = ST_ACK;
                        fire    = 1'b1;
                        f_port  = gnt;
                        f_addr  = addr_d;
                        f_we    = we_d;
                        f_wdata = wdata_d;
                    end else begin
                        state_d = ST_WAITS;
                    end
                end
            end
            ST_WAITS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                    fire    = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        f_oor  = ({1'b0, f_addr} >= DEPTH_LIM);
        f_idx  = f_addr[IW-1:0];
        mem_rd = mem[f_idx];
        mem_we = fire && (f_port == PORT_D) && f_we && !f_oor;

        if (fire) begin
            if (f_port == PORT_D) begin
                err_d     = f_oor;
                d_rdata_d = (f_we || f_oor) ? '0 : mem_rd;
            end else begin
                err_d     = 1'b0;
                i_rdata_d = f_oor ? '0 : mem_rd;
            end
        end
    end

    // State and latched-operand registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_I;
            rr_q      <= PORT_D;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Word memory write port; contents survive reset.
    always_ff @(posedge clk1) begin
        if (mem_we) begin
            mem[f_idx] <= f_wdata;
        end
    end

    assign i_ack   = (state_q == ST_ACK) && (port_q == PORT_I);
    assign d_ack   = (state_q == ST_ACK) && (port_q == PORT_D);
    assign d_err   = d_ack && err_q;
    assign busy    = (state_q != ST_IDLE);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: instance A (WAIT=2, DPRIO=1,
// DEPTH=1024) and instance B (WAIT=0, DPRIO=0, DEPTH=512).
module tb_mips_mem_responder;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int checks   = 0;
    int failures = 0;

    logic        a_rst_n, a_i_req, a_i_ack, a_d_req, a_d_we, a_d_ack, a_d_err, a_busy;
    logic [9:0]  a_i_addr, a_d_addr;
    logic [31:0] a_i_rdata, a_d_wdata, a_d_rdata;
    logic        b_rst_n, b_i_req, b_i_ack, b_d_req, b_d_we, b_d_ack, b_d_err, b_busy;
    logic [9:0]  b_i_addr, b_d_addr;
    logic [31:0] b_i_rdata, b_d_wdata, b_d_rdata;

    mips_mem_responder #(.AW(10), .DEPTH(1024), .WAIT(2), .DPRIO(1'b1)) u_dut_a (
        .clk1(clk1), .rst_n(a_rst_n),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata), .d_err(a_d_err), .busy(a_busy)
    );

    mips_mem_responder #(.AW(10), .DEPTH(512), .WAIT(0), .DPRIO(1'b0)) u_dut_b (
        .clk1(clk1), .rst_n(b_rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_err(b_d_err), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic drive(input bit inst, input bit is_d, input bit req, input bit we,
                         input logic [9:0] addr, input logic [31:0] wdata);
        if (!inst) begin
            if (is_d) begin
                a_d_req = req; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
            end else begin
                a_i_req = req; a_i_addr = addr;
            end
        end else begin
            if (is_d) begin
                b_d_req = req; b_d_we = we; b_d_addr = addr; b_d_wdata = wdata;
            end else begin
                b_i_req = req; b_i_addr = addr;
            end
        end
    endtask

    function automatic logic ack_of(input bit inst, input bit is_d);
        if (!inst) return is_d ? a_d_ack : a_i_ack;
        return is_d ? b_d_ack : b_i_ack;
    endfunction

    function automatic logic [31:0] rd_of(input bit inst, input bit is_d);
        if (!inst) return is_d ? a_d_rdata : a_i_rdata;
        return is_d ? b_d_rdata : b_i_rdata;
    endfunction

    // One access: n = ticks from request edge until ack seen (20 = timed out).
    task automatic access(input bit inst, input bit is_d, input bit we,
                          input logic [9:0] addr, input logic [31:0] wdata,
                          output int n, output logic [31:0] rdata, output logic err);
        bit seen;
        seen = 1'b0;
        n    = 0;
        drive(inst, is_d, 1'b1, we, addr, wdata);
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = ack_of(inst, is_d);
        end
        rdata = rd_of(inst, is_d);
        err   = inst ? b_d_err : a_d_err;
        drive(inst, is_d, 1'b0, we, addr, wdata);
        tick();
    endtask

    // Fetch and data acks must never coincide on either instance.
    always @(negedge clk1) begin
        if (a_rst_n && b_rst_n) begin
            chk("no_overlap_a", {31'b0, a_i_ack & a_d_ack}, 32'd0);
            chk("no_overlap_b", {31'b0, b_i_ack & b_d_ack}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, td, ti, idx;
        logic [31:0] rd, rdd, rdi;
        logic        er;
        logic [9:0]  faddr [4];
        logic [31:0] fval  [3];

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_i_req = 0; a_i_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
        b_i_req = 0; b_i_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
        tick();
        tick();
        chk("rst_i_ack",   {31'b0, a_i_ack}, 0);
        chk("rst_d_ack",   {31'b0, a_d_ack}, 0);
        chk("rst_d_err",   {31'b0, a_d_err}, 0);
        chk("rst_busy",    {31'b0, a_busy}, 0);
        chk("rst_i_rdata", a_i_rdata, 0);
        chk("rst_d_rdata", a_d_rdata, 0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // WAIT=2 store then fetch of the same word.
        access(0, 1, 1, 10'd5, 32'hDEADBEEF, n, rd, er);
        chk("t1_st_lat", n, 3);
        chk("t1_st_err", {31'b0, er}, 0);
        chk("t1_st_rdata", rd, 0);
        chk("t1_idle_busy", {31'b0, a_busy}, 0);
        access(0, 0, 0, 10'd5, 32'h0, n, rd, er);
        chk("t1_fe_lat", n, 3);
        chk("t1_fe_rdata", rd, 32'hDEADBEEF);

        // Operands changed during WAITS must not affect the latched access.
        access(0, 1, 1, 10'd21, 32'h0, n, rd, er);
        drive(0, 1, 1'b1, 1'b1, 10'd20, 32'hCAFEF00D);
        tick();
        chk("t6_busy", {31'b0, a_busy}, 1);
        drive(0, 1, 1'b1, 1'b1, 10'd21, 32'hBAD0BAD0);
        n = 1;
        while (!a_d_ack && n < 20) begin
            tick();
            n++;
        end
        chk("t6_lat", n, 3);
        drive(0, 1, 1'b0, 1'b0, 10'd0, 32'h0);
        tick();
        access(0, 1, 0, 10'd20, 32'h0, n, rd, er);
        chk("t6_ld20", rd, 32'hCAFEF00D);
        access(0, 1, 0, 10'd21, 32'h0, n, rd, er);
        chk("t6_ld21", rd, 32'h0);

        // DPRIO=1 tie: data first, fetch 4 cycles later.
        access(0, 1, 1, 10'd7, 32'h11, n, rd, er);
        a_i_req = 1; a_i_addr = 10'd5;
        a_d_req = 1; a_d_we = 0; a_d_addr = 10'd7;
        td = 0; ti = 0; rdd = '0; rdi = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (a_d_ack) begin td = t; rdd = a_d_rdata; a_d_req = 0; end
            if (a_i_ack) begin ti = t; rdi = a_i_rdata; a_i_req = 0; end
        end
        chk("t2_d_cycle", td, 3);
        chk("t2_i_cycle", ti, 7);
        chk("t2_d_rdata", rdd, 32'h11);
        chk("t2_i_rdata", rdi, 32'hDEADBEEF);

        // Reset during WAITS of a store drops it.
        access(0, 1, 1, 10'd9, 32'hAAAA5555, n, rd, er);
        drive(0, 1, 1'b1, 1'b1, 10'd9, 32'h12345678);
        tick();
        tick();
        a_rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'b0, a_busy}, 0);
        chk("t5_d_ack", {31'b0, a_d_ack}, 0);
        chk("t5_i_ack", {31'b0, a_i_ack}, 0);
        drive(0, 1, 1'b0, 1'b0, 10'd0, 32'h0);
        tick();
        a_rst_n = 1'b1;
        tick();
        access(0, 1, 0, 10'd9, 32'h0, n, rd, er);
        chk("t5_lat", n, 3);
        chk("t5_ld9", rd, 32'hAAAA5555);

        // Instance B preload (WAIT=0, DEPTH=512).
        access(1, 1, 1, 10'd1, 32'h101, n, rd, er);
        chk("b_st_lat", n, 1);
        access(1, 1, 1, 10'd2, 32'h202, n, rd, er);
        access(1, 1, 1, 10'd3, 32'h303, n, rd, er);
        access(1, 1, 1, 10'd88, 32'h88888888, n, rd, er);
        access(1, 1, 1, 10'd511, 32'h00511511, n, rd, er);

        // WAIT=0 fetch held high: ack every second cycle.
        faddr[0] = 10'd1; faddr[1] = 10'd2; faddr[2] = 10'd3; faddr[3] = 10'd1;
        fval[0] = 32'h101; fval[1] = 32'h202; fval[2] = 32'h303;
        idx = 0;
        b_i_req = 1; b_i_addr = faddr[0];
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("t3_ack", {31'b0, b_i_ack}, (t % 2 == 1) ? 1 : 0);
            if (b_i_ack && idx < 3) begin
                chk("t3_rdata", b_i_rdata, fval[idx]);
                idx++;
                b_i_addr = faddr[idx];
            end
        end
        b_i_req = 0;
        tick();

        // Out-of-range accesses with DEPTH=512.
        access(1, 1, 1, 10'd600, 32'h5, n, rd, er);
        chk("t4_st_lat", n, 1);
        chk("t4_st_err", {31'b0, er}, 1);
        access(1, 1, 0, 10'd88, 32'h0, n, rd, er);
        chk("t4_alias_rdata", rd, 32'h88888888);
        chk("t4_alias_err", {31'b0, er}, 0);
        access(1, 1, 0, 10'd600, 32'h0, n, rd, er);
        chk("t4_ld_rdata", rd, 0);
        chk("t4_ld_err", {31'b0, er}, 1);
        access(1, 1, 0, 10'd511, 32'h0, n, rd, er);
        chk("t4_511_rdata", rd, 32'h00511511);
        chk("t4_511_err", {31'b0, er}, 0);
        access(1, 1, 0, 10'd512, 32'h0, n, rd, er);
        chk("t4_512_rdata", rd, 0);
        chk("t4_512_err", {31'b0, er}, 1);
        access(1, 0, 0, 10'd600, 32'h0, n, rd, er);
        chk("t4_fe_rdata", rd, 0);

        // DPRIO=0 ties alternate, starting with fetch after reset.
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        tick();
        b_i_req = 1; b_i_addr = 10'd1;
        b_d_req = 1; b_d_we = 0; b_d_addr = 10'd2;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("rr_i_ack", {31'b0, b_i_ack}, (t == 1 || t == 5) ? 1 : 0);
            chk("rr_d_ack", {31'b0, b_d_ack}, (t == 3 || t == 7) ? 1 : 0);
            if (t == 1) chk("rr_i_rdata", b_i_rdata, 32'h101);
            if (t == 3) chk("rr_d_rdata", b_d_rdata, 32'h202);
        end
        b_i_req = 0; b_d_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
